// File: rtl/pixel_row_readout.sv
// Captures one pixel row and streams it out one pixel per valid/ready beat.
// Optional checksum beat after each row when PIXEL_READOUT_CHECKSUM_EN is set.
//
// Ports:
//   CLK, RESET (sync, active-high)
//   ROW_DATA/ROW_VALID/ROW_READY  : parallel row capture
//   FRAME_START                   : next captured row becomes row 0
//   OUT_DATA/OUT_VALID/OUT_READY  : pixel stream handshake
//   OUT_COL/OUT_ROW               : beat indices
//   OUT_SOF/OUT_EOL/OUT_EOF       : frame markers
//   OUT_CHK                       : checksum beat flag (checksum build only)
//   OVERRUN                       : sticky, row offered while busy
module pixel_row_readout #(
  parameter  int WIDTH  = 4,
  parameter  int HEIGHT = 2,
  parameter  int BITS   = 8,
  localparam int CW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [WIDTH*BITS-1:0] ROW_DATA,
  input  logic                  ROW_VALID,
  output logic                  ROW_READY,
  input  logic                  FRAME_START,
  output logic [BITS-1:0]       OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [CW-1:0]         OUT_COL,
  output logic [RW-1:0]         OUT_ROW,
  output logic                  OUT_SOF,
  output logic                  OUT_EOL,
  output logic                  OUT_EOF,
`ifdef PIXEL_READOUT_CHECKSUM_EN
  output logic                  OUT_CHK,
`endif
  output logic                  OVERRUN
);

`ifdef PIXEL_READOUT_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE, SHIFT, CHKSUM
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE, SHIFT
  } state_e;
`endif

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  state_e          state_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            pend_q;
  logic            ovr_q;
  logic [BITS-1:0] pix_q [WIDTH];

  logic            busy;
  logic            beat;
  logic            col_last;
  logic [RW-1:0]   row_d;
  logic            eol_w;

  assign busy     = (state_q != IDLE);
  assign beat     = busy && OUT_READY;
  assign col_last = (col_q == COL_LAST);

  // A frame start seen during the row (or on its last beat)
  // restarts numbering instead of advancing.
  always_comb begin
    row_d = row_q + RW'(1);
    if (pend_q || FRAME_START) begin
      row_d = '0;
    end else if (row_q == ROW_LAST) begin
      row_d = '0;
    end
  end

`ifdef PIXEL_READOUT_CHECKSUM_EN
  logic [BITS-1:0] sum_w;

  always_comb begin
    sum_w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_w = sum_w + pix_q[i];
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        pix_q[i] <= '0;
      end
    end else begin
      if (ROW_VALID && busy) begin
        ovr_q <= 1'b1;
      end else if (FRAME_START) begin
        ovr_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (FRAME_START) begin
            row_q <= '0;
          end
          if (ROW_VALID) begin
            for (int i = 0; i < WIDTH; i++) begin
              pix_q[i] <= ROW_DATA[i*BITS +: BITS];
            end
            col_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (FRAME_START) begin
            pend_q <= 1'b1;
          end
          if (beat) begin
            if (!col_last) begin
              col_q <= col_q + CW'(1);
            end else begin
`ifdef PIXEL_READOUT_CHECKSUM_EN
              state_q <= CHKSUM;
`else
              row_q   <= row_d;
              col_q   <= '0;
              pend_q  <= 1'b0;
              state_q <= IDLE;
`endif
            end
          end
        end
`ifdef PIXEL_READOUT_CHECKSUM_EN
        CHKSUM: begin
          if (FRAME_START) begin
            pend_q <= 1'b1;
          end
          if (beat) begin
            row_q   <= row_d;
            col_q   <= '0;
            pend_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PIXEL_READOUT_CHECKSUM_EN
  assign eol_w    = (state_q == CHKSUM);
  assign OUT_CHK  = eol_w;
  assign OUT_DATA = !busy  ? '0 :
                    eol_w  ? sum_w : pix_q[col_q];
`else
  assign eol_w    = (state_q == SHIFT) && col_last;
  assign OUT_DATA = busy ? pix_q[col_q] : '0;
`endif

  assign ROW_READY = !busy;
  assign OUT_VALID = busy;
  assign OUT_COL   = col_q;
  assign OUT_ROW   = row_q;
  assign OUT_SOF   = (state_q == SHIFT) &&
                     (row_q == '0) && (col_q == '0);
  assign OUT_EOL   = eol_w;
  assign OUT_EOF   = eol_w && (row_q == ROW_LAST);
  assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_pixel_row_readout.sv
// Scoreboard bench for pixel_row_readout (WIDTH=4, HEIGHT=2, BITS=8).
// Expected beats are queued at capture; a negedge monitor pops and compares.
module tb_pixel_row_readout;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] ROW_DATA = '0;
  logic        ROW_VALID = 1'b0;
  logic        ROW_READY;
  logic        FRAME_START = 1'b0;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [1:0]  OUT_COL;
  logic        OUT_ROW;
  logic        OUT_SOF;
  logic        OUT_EOL;
  logic        OUT_EOF;
  logic        OUT_CHK;
  logic        OVERRUN;

  always #5 CLK = ~CLK;

  pixel_row_readout #(.WIDTH(4), .HEIGHT(2), .BITS(8)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ROW_DATA(ROW_DATA),
    .ROW_VALID(ROW_VALID),
    .ROW_READY(ROW_READY),
    .FRAME_START(FRAME_START),
    .OUT_DATA(OUT_DATA),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_COL(OUT_COL),
    .OUT_ROW(OUT_ROW),
    .OUT_SOF(OUT_SOF),
    .OUT_EOL(OUT_EOL),
    .OUT_EOF(OUT_EOF),
`ifdef PIXEL_READOUT_CHECKSUM_EN
    .OUT_CHK(OUT_CHK),
`endif
    .OVERRUN(OVERRUN)
  );

`ifndef PIXEL_READOUT_CHECKSUM_EN
  assign OUT_CHK = 1'b0;
  localparam int CHK = 0;
`else
  localparam int CHK = 1;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] c;
    logic       r;
    logic       sof;
    logic       eol;
    logic       eof;
    logic       chk;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    pushed = 0;
  int    popped = 0;
  int    mnext  = 0;

  logic       stall_prev = 1'b0;
  logic [7:0] prev_d = '0;
  logic [1:0] prev_c = '0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      if (stall_prev) begin
        checks++;
        if (!OUT_VALID || OUT_DATA !== prev_d || OUT_COL !== prev_c) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%0h c=%0d expected d=%0h c=%0d",
                   OUT_VALID, OUT_DATA, OUT_COL, prev_d, prev_c);
        end
      end
      if (OUT_VALID && OUT_READY) begin
        beat_t a;
        beat_t e;
        a = '{OUT_DATA, OUT_COL, OUT_ROW, OUT_SOF, OUT_EOL, OUT_EOF, OUT_CHK};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got %p expected none", a);
        end else begin
          e = sb.pop_front();
          popped++;
          if (a !== e) begin
            errors++;
            $display("FAIL beat: got %p expected %p", a, e);
          end
        end
      end
      stall_prev <= OUT_VALID && !OUT_READY;
      prev_d     <= OUT_DATA;
      prev_c     <= OUT_COL;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_row(input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input logic [7:0] p3,
                          input logic fs);
    int n;
    int r;
    logic [7:0] p [4];
    logic [7:0] sum;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    n = 0;
    while (!ROW_READY && n < 50) begin
      step();
      n++;
    end
    check("ready_wait", {31'd0, ROW_READY}, 32'd1);
    ROW_DATA    = {p3, p2, p1, p0};
    ROW_VALID   = 1'b1;
    FRAME_START = fs;
    if (fs) mnext = 0;
    r = mnext;
    sum = '0;
    for (int c = 0; c < 4; c++) begin
      sum = sum + p[c];
      sb.push_back('{p[c], 2'(c), r[0],
                     (r == 0 && c == 0),
                     (c == 3 && CHK == 0),
                     (c == 3 && CHK == 0 && r == 1),
                     1'b0});
      pushed++;
    end
    if (CHK != 0) begin
      sb.push_back('{sum, 2'd3, r[0], 1'b0, 1'b1, (r == 1), 1'b1});
      pushed++;
    end
    mnext = (r == 1) ? 0 : r + 1;
    step();
    ROW_VALID   = 1'b0;
    FRAME_START = 1'b0;
  endtask

  initial begin
    int n;
    // 1: reset
    step();
    step();
    check("rst_ready", {31'd0, ROW_READY}, 32'd1);
    check("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_overrun", {31'd0, OVERRUN}, 32'd0);
    check("rst_row", {31'd0, OUT_ROW}, 32'd0);
    check("rst_col", {30'd0, OUT_COL}, 32'd0);
    RESET = 1'b0;
    step();
    check("post_rst_ready", {31'd0, ROW_READY}, 32'd1);

    // 2: first row with frame start, row period
    send_row(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    check("valid_after_cap", {31'd0, OUT_VALID}, 32'd1);
    check("sof_first", {31'd0, OUT_SOF}, 32'd1);
    n = 0;
    while (!ROW_READY && n < 20) begin
      step();
      n++;
    end
    check("row_busy_cycles", n, 4 + CHK);

    // 3: row 1 with EOF, then wrap to row 0
    send_row(8'hA0, 8'hB0, 8'hC0, 8'hD0, 1'b0);
    send_row(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);

    // 4: stall on col 1
    send_row(8'h55, 8'h66, 8'h77, 8'h88, 1'b0);
    step();
    OUT_READY = 1'b0;
    check("stall_col", {30'd0, OUT_COL}, 32'd1);
    check("stall_data", {24'd0, OUT_DATA}, 32'h66);
    repeat (3) step();
    check("stall_col_end", {30'd0, OUT_COL}, 32'd1);
    OUT_READY = 1'b1;

    // 5: overrun during shift, then frame start mid-row
    send_row(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    ROW_DATA  = 32'hDEADBEEF;
    ROW_VALID = 1'b1;
    step();
    ROW_VALID = 1'b0;
    check("overrun_set", {31'd0, OVERRUN}, 32'd1);
    FRAME_START = 1'b1;
    mnext = 0;
    step();
    FRAME_START = 1'b0;
    check("overrun_clr", {31'd0, OVERRUN}, 32'd0);

    // 6: checksum pattern, row 0 after mid-row frame start
    send_row(8'hFF, 8'h02, 8'h10, 8'h01, 1'b0);
    check("row0_after_fs", {31'd0, OUT_ROW}, 32'd0);
    send_row(8'h9A, 8'hBC, 8'hDE, 8'hF0, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    step();
    check("drain", sb.size(), 0);
    check("beat_count", popped, pushed);
    check("end_ready", {31'd0, ROW_READY}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
